// File: rtl/digit_serial_addsub.sv
// Digit-serial adder/subtractor: adds or subtracts two N-bit operands D bits per cycle,
// LSB digit first, with a registered carry between digits and valid/ready handshakes.
module digit_serial_addsub #(
    parameter int N = 16,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out,
    output logic         c_out,
    output logic         ovf
);
    localparam int DIGITS = N / D;
    localparam int KW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    generate
        if (D < 1 || (N % D) != 0) begin : g_param_check
            $error("digit_serial_addsub: D must be >= 1 and divide N");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic [N-1:0]  r_sum;
    logic          r_carry;
    logic [KW-1:0] r_k;
    logic          r_in_ready;

    logic          w_accept;
    logic          w_last;
    logic [D:0]    w_digit;
    logic [N-1:0]  w_sum_next;
    logic          w_msb_cin;

    assign w_accept  = (r_state == IDLE) && r_in_ready && in_valid;
    assign w_last    = (r_k == KW'(DIGITS - 1));

    // Operands shift right so the active digit is always in the low D bits;
    // result digits enter from the top of r_sum.
    assign w_digit    = {1'b0, r_a[D-1:0]} + {1'b0, r_b[D-1:0]} + (D+1)'(r_carry);
    assign w_sum_next = (r_sum >> D) | (N'(w_digit[D-1:0]) << (N - D));
    // Carry into the top bit of the slice, recovered from the sum bit.
    assign w_msb_cin  = r_a[D-1] ^ r_b[D-1] ^ w_digit[D-1];

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_state_next = BUSY;
            BUSY:    if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_ready <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_sum      <= '0;
            r_carry    <= 1'b0;
            r_k        <= '0;
            out        <= '0;
            c_out      <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            r_in_ready <= (w_state_next == IDLE);
            if (w_accept) begin
                r_a     <= a;
                r_b     <= sub ? ~b : b;
                r_carry <= sub ^ c_in;
                r_k     <= '0;
            end else if (r_state == BUSY) begin
                r_a     <= r_a >> D;
                r_b     <= r_b >> D;
                r_carry <= w_digit[D];
                r_sum   <= w_sum_next;
                r_k     <= r_k + 1'b1;
                if (w_last) begin
                    out   <= w_sum_next;
                    c_out <= w_digit[D];
                    ovf   <= w_msb_cin ^ w_digit[D];
                end
            end
        end
    end

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Bench for digit_serial_addsub: three instances (D=4, 16, 1) share stimulus and are
// checked against an integer-arithmetic reference model.
module tb_digit_serial_addsub;
    localparam int N  = 16;
    localparam int NI = 3;
    localparam int DV [NI] = '{4, 16, 1};

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         c_in = 1'b0;
    logic         sub = 1'b0;
    logic         out_ready = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;

    logic         w_in_ready  [NI];
    logic         w_out_valid [NI];
    logic         w_c_out     [NI];
    logic         w_ovf       [NI];
    logic [N-1:0] w_out       [NI];

    int           checks = 0;
    int           errors = 0;
    int           got_lat [NI];
    logic [N-1:0] got_out [NI];
    logic         got_c   [NI];
    logic         got_ov  [NI];

    always #5 clk = ~clk;

    digit_serial_addsub #(.N(N), .D(4)) u_d4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready[0]),
        .a(a), .b(b), .c_in(c_in), .sub(sub),
        .out_valid(w_out_valid[0]), .out_ready(out_ready),
        .out(w_out[0]), .c_out(w_c_out[0]), .ovf(w_ovf[0])
    );
    digit_serial_addsub #(.N(N), .D(16)) u_d16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready[1]),
        .a(a), .b(b), .c_in(c_in), .sub(sub),
        .out_valid(w_out_valid[1]), .out_ready(out_ready),
        .out(w_out[1]), .c_out(w_c_out[1]), .ovf(w_ovf[1])
    );
    digit_serial_addsub #(.N(N), .D(1)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready[2]),
        .a(a), .b(b), .c_in(c_in), .sub(sub),
        .out_valid(w_out_valid[2]), .out_ready(out_ready),
        .out(w_out[2]), .c_out(w_c_out[2]), .ovf(w_ovf[2])
    );

    // Reference: exact integer arithmetic, unsigned for result/carry, signed for overflow.
    function automatic void model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                  input logic mc, input logic ms,
                                  output logic [N-1:0] r, output logic co, output logic ov);
        longint ua, ub, sa, sb, ures, sres;
        ua = longint'(ma);
        ub = longint'(mb);
        sa = ma[N-1] ? ua - (longint'(1) << N) : ua;
        sb = mb[N-1] ? ub - (longint'(1) << N) : ub;
        if (ms) begin
            ures = ua - ub - longint'(mc);
            sres = sa - sb - longint'(mc);
            co   = (ures >= 0);
        end else begin
            ures = ua + ub + longint'(mc);
            sres = sa + sb + longint'(mc);
            co   = (ures >= (longint'(1) << N));
        end
        r  = ures[N-1:0];
        ov = (sres >= (longint'(1) << (N - 1))) || (sres < -(longint'(1) << (N - 1)));
    endfunction

    // Drives one operation into all instances and records latency and outputs per instance.
    task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tbv, input logic tc,
                          input logic ts, input logic ready_during, input logic release_after);
        bit all_seen;
        for (int w = 0; w < 40; w++) begin
            if (w_in_ready[0] && w_in_ready[1] && w_in_ready[2]) break;
            @(posedge clk); #1;
        end
        a = ta; b = tbv; c_in = tc; sub = ts; in_valid = 1'b1; out_ready = ready_during;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
        for (int i = 0; i < NI; i++) got_lat[i] = -1;
        for (int cyc = 0; cyc <= 40; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
            end
            all_seen = 1'b1;
            for (int i = 0; i < NI; i++) begin
                if (got_lat[i] < 0 && w_out_valid[i]) begin
                    got_lat[i] = cyc;
                    got_out[i] = w_out[i];
                    got_c[i]   = w_c_out[i];
                    got_ov[i]  = w_ovf[i];
                end
                if (got_lat[i] < 0) all_seen = 1'b0;
            end
            if (all_seen) break;
        end
        if (release_after) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if ({w_out[i], w_c_out[i], w_ovf[i], w_out_valid[i], w_in_ready[i]} !== '0) begin
                errors++;
                $display("FAIL reset_values d%0d got out=%h c=%b ovf=%b ov=%b ir=%b exp all 0",
                         DV[i], w_out[i], w_c_out[i], w_ovf[i], w_out_valid[i], w_in_ready[i]);
            end
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (w_in_ready[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_release_ready d%0d got %b exp 0", DV[i], w_in_ready[i]);
            end
        end
        @(posedge clk); #1;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (w_in_ready[i] !== 1'b1) begin
                errors++;
                $display("FAIL reset_first_edge_ready d%0d got %b exp 1", DV[i], w_in_ready[i]);
            end
        end
    endtask

    task automatic test_directed();
        logic [N-1:0] ta [5];
        logic [N-1:0] tbv[5];
        logic [N-1:0] eo [5];
        logic         tc [5];
        logic         ts [5];
        logic         ec [5];
        logic         ev [5];
        ta  = '{16'h1234, 16'hFFFF, 16'h0005, 16'h7FFF, 16'h8000};
        tbv = '{16'h0FFF, 16'h0000, 16'h0007, 16'h0001, 16'h0001};
        tc  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        ts  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        eo  = '{16'h2233, 16'h0000, 16'hFFFE, 16'h8000, 16'h7FFF};
        ec  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        ev  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int v = 0; v < 5; v++) begin
            run_op(ta[v], tbv[v], tc[v], ts[v], 1'b0, 1'b1);
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (got_lat[i] !== N / DV[i] || got_out[i] !== eo[v] ||
                    got_c[i] !== ec[v] || got_ov[i] !== ev[v]) begin
                    errors++;
                    $display("FAIL directed%0d d%0d got lat=%0d out=%h c=%b ovf=%b exp lat=%0d out=%h c=%b ovf=%b",
                             v, DV[i], got_lat[i], got_out[i], got_c[i], got_ov[i],
                             N / DV[i], eo[v], ec[v], ev[v]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] eo;
        logic         ec, ev;
        run_op(16'hABCD, 16'h5678, 1'b1, 1'b1, 1'b0, 1'b0);
        model(16'hABCD, 16'h5678, 1'b1, 1'b1, eo, ec, ev);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (got_lat[i] !== N / DV[i] || got_out[i] !== eo || got_c[i] !== ec || got_ov[i] !== ev) begin
                errors++;
                $display("FAIL bp_result d%0d got lat=%0d out=%h c=%b ovf=%b exp lat=%0d out=%h c=%b ovf=%b",
                         DV[i], got_lat[i], got_out[i], got_c[i], got_ov[i], N / DV[i], eo, ec, ev);
            end
        end
        for (int cyc = 0; cyc < 5; cyc++) begin
            in_valid = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
            c_in = 1'($urandom); sub = 1'($urandom);
            @(posedge clk); #1;
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (w_out_valid[i] !== 1'b1 || w_in_ready[i] !== 1'b0 ||
                    w_out[i] !== eo || w_c_out[i] !== ec || w_ovf[i] !== ev) begin
                    errors++;
                    $display("FAIL bp_hold c%0d d%0d got ov=%b ir=%b out=%h c=%b ovf=%b exp ov=1 ir=0 out=%h c=%b ovf=%b",
                             cyc, DV[i], w_out_valid[i], w_in_ready[i], w_out[i], w_c_out[i], w_ovf[i], eo, ec, ev);
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (w_out_valid[i] !== 1'b0 || w_in_ready[i] !== 1'b1 || w_out[i] !== eo) begin
                errors++;
                $display("FAIL bp_release d%0d got ov=%b ir=%b out=%h exp ov=0 ir=1 out=%h",
                         DV[i], w_out_valid[i], w_in_ready[i], w_out[i], eo);
            end
        end
        run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (got_lat[i] !== N / DV[i] || got_out[i] !== 16'h1000 || got_c[i] !== 1'b0 || got_ov[i] !== 1'b0) begin
                errors++;
                $display("FAIL bp_next d%0d got lat=%0d out=%h c=%b ovf=%b exp lat=%0d out=1000 c=0 ovf=0",
                         DV[i], got_lat[i], got_out[i], got_c[i], got_ov[i], N / DV[i]);
            end
        end
    endtask

    task automatic test_reset_midop();
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
        a = 16'h1234; b = 16'h4321; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if ({w_out[i], w_c_out[i], w_ovf[i], w_out_valid[i], w_in_ready[i]} !== '0) begin
                errors++;
                $display("FAIL midop_async_reset d%0d got out=%h c=%b ovf=%b ov=%b ir=%b exp all 0",
                         DV[i], w_out[i], w_c_out[i], w_ovf[i], w_out_valid[i], w_in_ready[i]);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (w_in_ready[i] !== 1'b0 || w_out_valid[i] !== 1'b0) begin
                errors++;
                $display("FAIL midop_released d%0d got ir=%b ov=%b exp ir=0 ov=0",
                         DV[i], w_in_ready[i], w_out_valid[i]);
            end
        end
        @(posedge clk); #1;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (w_in_ready[i] !== 1'b1) begin
                errors++;
                $display("FAIL midop_ready d%0d got %b exp 1", DV[i], w_in_ready[i]);
            end
        end
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (got_lat[i] !== N / DV[i] || got_out[i] !== 16'h0100 || got_c[i] !== 1'b0 || got_ov[i] !== 1'b0) begin
                errors++;
                $display("FAIL midop_next d%0d got lat=%0d out=%h c=%b ovf=%b exp lat=%0d out=0100 c=0 ovf=0",
                         DV[i], got_lat[i], got_out[i], got_c[i], got_ov[i], N / DV[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] edges [4];
        logic [N-1:0] ra, rb, eo;
        logic         rc, rs, ec, ev;
        edges = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};
        for (int n = 0; n < 30; n++) begin
            ra = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : 16'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            model(ra, rb, rc, rs, eo, ec, ev);
            run_op(ra, rb, rc, rs, 1'b1, 1'b0);
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (got_lat[i] !== N / DV[i] || got_out[i] !== eo || got_c[i] !== ec || got_ov[i] !== ev) begin
                    errors++;
                    $display("FAIL b2b%0d d%0d a=%h b=%h ci=%b sub=%b got lat=%0d out=%h c=%b ovf=%b exp lat=%0d out=%h c=%b ovf=%b",
                             n, DV[i], ra, rb, rc, rs, got_lat[i], got_out[i], got_c[i], got_ov[i],
                             N / DV[i], eo, ec, ev);
                end
            end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
